// File: rtl/mips_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_fetch : MIPS instruction-fetch stage (PC, IR, imem req/ack, next-PC) |
// | Optional: EXC_VECTOR_EN enables exception redirect and EPC capture.      |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module mips_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  control_type,
  input  logic [31:0] rs_data,
  input  logic        except,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] inst_count
);

  typedef enum logic [0:0] {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_started;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_count;
  logic        w_req;
  logic        w_valid;
  logic        w_load_ir;
  logic        w_accept;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // r_started keeps imem_req low until the first clock after reset release
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    w_load_ir    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req = r_started;
        if (r_started && imem_ack) begin
          w_load_ir    = 1'b1;
          w_next_state = S_VALID;
        end
      end
      S_VALID: begin
        w_valid = 1'b1;
        if (inst_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc4;
    case (control_type)
      2'd0:    w_next_pc = w_pc4;
      2'd1:    w_next_pc = w_pc4 + w_br_off;
      2'd2:    w_next_pc = {w_pc4[31:28], r_ir[25:0], 2'b00};
      default: w_next_pc = {rs_data[31:2], 2'b00};
    endcase
`ifdef EXC_VECTOR_EN
    if (except) begin
      w_next_pc = EXC_VECTOR;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_started <= 1'b0;
      r_pc      <= RESET_PC;
      r_ir      <= 32'h0;
      r_count   <= 32'h0;
    end else begin
      r_started <= 1'b1;
      if (w_load_ir) begin
        r_ir <= imem_rdata;
      end
      if (w_accept) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 32'd1;
      end
    end
  end

`ifdef EXC_VECTOR_EN
  logic [31:0] r_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc <= 32'h0;
    end else if (w_accept && except) begin
      r_epc <= r_pc;
    end
  end

  assign epc = r_epc;

  logic w_unused;
  assign w_unused = ^rs_data[1:0];
`else
  assign epc = 32'h0;

  logic w_unused;
  assign w_unused = ^{except, EXC_VECTOR, rs_data[1:0]};
`endif

  assign imem_req   = w_req;
  assign imem_addr  = r_pc[31:2];
  assign inst       = r_ir;
  assign opcode     = r_ir[31:26];
  assign funct      = r_ir[5:0];
  assign inst_valid = w_valid;
  assign pc         = r_pc;
  assign inst_count = r_count;

endmodule
`default_nettype wire
